// File: rtl/clk_sched_if.sv
// Configuration handshake for clk_sched: a new terminal count and LED mode offered over valid/ready.
interface clk_sched_if #(
  parameter int CNT_W = 27
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic [1:0]       cfg_mode;

  modport master (output cfg_valid, output cfg_div, output cfg_mode, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, input cfg_mode, output cfg_ready);
endinterface

// File: rtl/clk_sched.sv
// Tick scheduler and 16-bit LED sequencer; configuration is applied only at tick boundaries.
// Optional macro CLK_SCHED_SYNC_RUN_EN puts run_i through a two-flop synchronizer.
module clk_sched #(
  parameter int          CNT_W   = 27,
  parameter int unsigned DEF_DIV = 49_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  clk_sched_if.slave  cfg,
  output logic        tick_o,
  output logic [15:0] led_o,
  output logic        busy_o
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  logic [1:0]       sh_mode_q, sh_mode_d;
  logic             pend_q, pend_d;
  logic [15:0]      led_q, led_d;
  logic             tick_q, tick_d;
  logic             run_eff;
  logic             cfg_ready;
  logic             xfer;

  function automatic logic [15:0] led_step(input logic [15:0] led, input logic [1:0] mode);
    logic [15:0] r;
    case (mode)
      2'b00:   r = led + 16'd1;
      2'b01:   r = {led[14:0], led[15]};
      2'b11:   r = {led[0], led[15:1]};
      default: r = led;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] led_seed(input logic [1:0] mode, input logic [15:0] led);
    logic [15:0] r;
    case (mode)
      2'b00:   r = 16'h0000;
      2'b01:   r = 16'h0001;
      2'b11:   r = 16'h8000;
      default: r = led;
    endcase
    return r;
  endfunction

`ifdef CLK_SCHED_SYNC_RUN_EN
  logic run_s1_q, run_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      run_s1_q <= run_i;
      run_s2_q <= run_s1_q;
    end
  end

  assign run_eff = run_s2_q;
`else
  assign run_eff = run_i;
`endif

  assign cfg_ready     = !pend_q && (state_q != S_LOAD);
  assign cfg.cfg_ready = cfg_ready;
  assign xfer          = cfg.cfg_valid && cfg_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    mode_d    = mode_q;
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    led_d     = led_q;
    tick_d    = 1'b0;

    if (xfer) begin
      sh_div_d  = cfg.cfg_div;
      sh_mode_d = cfg.cfg_mode;
      pend_d    = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // A transfer on this edge holds off RUN so the new setting is loaded first.
        if (pend_q)                state_d = S_LOAD;
        else if (run_eff && !xfer) state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == div_q) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          led_d  = led_step(led_q, mode_q);
          if (!run_eff)    state_d = S_IDLE;
          else if (pend_q) state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!run_eff) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        div_d   = sh_div_q;
        mode_d  = sh_mode_q;
        pend_d  = 1'b0;
        cnt_d   = '0;
        led_d   = led_seed(sh_mode_q, led_q);
        state_d = run_eff ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= DEF_DIV_C;
      mode_q    <= 2'b00;
      sh_div_q  <= '0;
      sh_mode_q <= 2'b00;
      pend_q    <= 1'b0;
      led_q     <= 16'h0000;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      sh_div_q  <= sh_div_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign led_o  = led_q;
  assign busy_o = (state_q == S_RUN) || (state_q == S_LOAD);

endmodule

// File: tb/tb_clk_sched.sv
// Bench for clk_sched: directed scenarios plus random run/config traffic against a cycle reference model.
module tb_clk_sched;
  localparam int CNT_W   = 27;
  localparam int DEF_DIV = 3;

  logic        clk;
  logic        rst;
  logic        run;
  logic        tick;
  logic [15:0] led;
  logic        busy;

  clk_sched_if #(.CNT_W(CNT_W)) cif ();

  clk_sched #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run),
    .cfg    (cif),
    .tick_o (tick),
    .led_o  (led),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: running/loading flags, a phase count within the period, and the display value.
  bit       m_active, m_loading, m_pend, m_tick, m_xfer;
  int       m_phase, m_div, m_mode, m_sdiv, m_smode, m_led;
  bit [1:0] m_sync;

  function automatic int seed_of(input int mode, input int cur);
    case (mode)
      0:       return 0;
      1:       return 1;
      3:       return 32'h8000;
      default: return cur;
    endcase
  endfunction

  function automatic int step_of(input int mode, input int cur);
    case (mode)
      0:       return (cur + 1) % 65536;
      1:       return ((cur << 1) | (cur >> 15)) & 32'hFFFF;
      3:       return ((cur >> 1) | ((cur & 1) << 15)) & 32'hFFFF;
      default: return cur;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_loading = 0; m_pend = 0; m_tick = 0; m_xfer = 0;
    m_phase = 0; m_div = DEF_DIV; m_mode = 0; m_sdiv = 0; m_smode = 0;
    m_led = 0; m_sync = 2'b00;
  endtask

  task automatic model_edge(input bit r, input bit v, input int d, input int md);
    bit run_eff;
    bit acc;
`ifdef CLK_SCHED_SYNC_RUN_EN
    run_eff = m_sync[1];
    m_sync  = {m_sync[0], r};
`else
    run_eff = r;
`endif
    acc    = v && !m_pend && !m_loading;
    m_tick = 0;
    if (m_loading) begin
      m_div     = m_sdiv;
      m_mode    = m_smode;
      m_pend    = 0;
      m_phase   = 0;
      m_led     = seed_of(m_smode, m_led);
      m_loading = 0;
      m_active  = run_eff;
    end else if (m_active) begin
      if (m_phase == m_div) begin
        m_tick  = 1;
        m_led   = step_of(m_mode, m_led);
        m_phase = 0;
        if (!run_eff) m_active = 0;
        else if (m_pend) begin
          m_active  = 0;
          m_loading = 1;
        end
      end else begin
        m_phase++;
        if (!run_eff) begin
          m_active = 0;
          m_phase  = 0;
        end
      end
    end else begin
      m_phase = 0;
      if (m_pend) m_loading = 1;
      else if (run_eff && !acc) m_active = 1;
    end
    if (acc) begin
      m_sdiv  = d;
      m_smode = md;
      m_pend  = 1;
    end
    m_xfer = acc;
  endtask

  task automatic step();
    bit r, v;
    int d, md;
    r  = run;
    v  = cif.cfg_valid;
    d  = 32'(cif.cfg_div);
    md = 32'(cif.cfg_mode);
    @(posedge clk);
    model_edge(r, v, d, md);
    #1;
    chk("tick",  32'(tick), 32'(m_tick));
    chk("led",   32'(led), m_led);
    chk("busy",  32'(busy), 32'(m_active || m_loading));
    chk("ready", 32'(cif.cfg_ready), 32'(!m_pend && !m_loading));
  endtask

  task automatic offer(input int d, input int md);
    bit got;
    got = 0;
    cif.cfg_valid = 1'b1;
    cif.cfg_div   = CNT_W'(d);
    cif.cfg_mode  = 2'(md);
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = m_xfer;
    end
    cif.cfg_valid = 1'b0;
    if (!got) chk("offer_timeout", 32'(got), 1);
    else      chk("ready_after_xfer", 32'(cif.cfg_ready), 0);
  endtask

  task automatic wait_load();
    for (int i = 0; i < 40 && !m_loading; i++) step();
    if (!m_loading) chk("load_timeout", 32'(m_loading), 1);
    else step();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_led",   32'(led), 0);
    chk("arst_tick",  32'(tick), 0);
    chk("arst_ready", 32'(cif.cfg_ready), 1);
    chk("arst_busy",  32'(busy), 0);
    #2 rst = 1'b0;
  endtask

  initial begin
    int tk;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    run = 1'b0;
    cif.cfg_valid = 1'b0;
    cif.cfg_div   = '0;
    cif.cfg_mode  = 2'b00;
    model_reset();
    #3;
    chk("rst_tick",  32'(tick), 0);
    chk("rst_led",   32'(led), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ready", 32'(cif.cfg_ready), 1);
    #9 rst = 1'b0;

    // Free-running count mode at the reset period
    run = 1'b1;
    tk = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (m_tick) begin
        tk++;
        chk($sformatf("t1_led%0d", tk), 32'(led), tk);
      end
    end
    chk("t1_busy", 32'(busy), 1);

    // Reconfigure to walk-left with period 2
    offer(1, 1);
    wait_load();
    chk("t2_seed", 32'(led), 32'h0001);
    step(); step();
    chk("t2_tick1", 32'(tick), 1);
    chk("t2_led1",  32'(led), 32'h0002);
    step(); step();
    chk("t2_tick2", 32'(tick), 1);
    chk("t2_led2",  32'(led), 32'h0004);

    // Walk-right with a tick every cycle
    offer(0, 3);
    wait_load();
    chk("t3_seed", 32'(led), 32'h8000);
    for (int i = 0; i < 16; i++) step();
    chk("t3_wrap", 32'(led), 32'h8000);
    step();
    chk("t3_tick17", 32'(tick), 1);

    // Drop run mid-period, then restart
    offer(3, 0);
    wait_load();
    step(); step();
    run = 1'b0;
    step();
`ifndef CLK_SCHED_SYNC_RUN_EN
    chk("t4_drop_tick", 32'(tick), 0);
    chk("t4_drop_busy", 32'(busy), 0);
`endif
    for (int i = 0; i < 4; i++) step();
    run = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
`ifndef CLK_SCHED_SYNC_RUN_EN
    chk("t4_not_yet", 32'(tick), 0);
`endif
    step();
`ifndef CLK_SCHED_SYNC_RUN_EN
    chk("t4_first_tick", 32'(tick), 1);
`endif

    // run rising together with a configuration offer in IDLE
    run = 1'b0;
    for (int i = 0; i < 6; i++) step();
    run = 1'b1;
    offer(2, 1);
    wait_load();
    chk("t5_seed", 32'(led), 32'h0001);
    step(); step();
    step();
    chk("t5_first_tick", 32'(tick), 1);

    // Asynchronous reset while a configuration is pending
    offer(5, 0);
    step();
    async_reset();
    for (int i = 0; i < 12; i++) step();

    // Random run toggling, offers and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run = !run;
      cif.cfg_valid = ($urandom_range(0, 9) == 0);
      cif.cfg_div   = CNT_W'($urandom_range(0, 5));
      cif.cfg_mode  = 2'($urandom_range(0, 3));
      step();
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    cif.cfg_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_sched.md
# clk_sched

Programmable tick scheduler and LED sequencer for the board clock-divider path. Divides the single system clock into a one-cycle `tick` enable with a runtime-configurable period. On each tick it steps a 16-bit LED pattern in the selected mode. Configuration arrives over a valid/ready handshake and is applied only at tick boundaries, so a running display never sees a truncated period.

## Interface
- `CNT_W`, 27: divide counter width.
- `DEF_DIV`, 49_999_999: reset terminal count. Tick period is `DEF_DIV+1` cycles, which is 0.5 s at 100 MHz.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level enable. 1 = divide and step; 0 = halt.
- `cfg_valid` in 1: configuration offer.
- `cfg_ready` out 1: configuration can be accepted this cycle.
- `cfg_div` in CNT_W: new terminal count. Period = `cfg_div+1` cycles; 0 means a tick every cycle.
- `cfg_mode` in 2: 00 binary up-count, 01 walk-left, 10 hold, 11 walk-right.
- `tick` out 1: registered one-cycle pulse at each period boundary.
- `led` out 16: pattern register.
- `busy` out 1: high while the state is RUN or LOAD.

## Operation
- Reset values: state IDLE, `cnt`=0, `div`=DEF_DIV, `mode`=00, `pend`=0, `led`=16'h0000, `tick`=0, `cfg_ready`=1, `busy`=0.
- Handshake:
  - Transfer occurs when `cfg_valid && cfg_ready` at a rising edge. `cfg_div`/`cfg_mode` are latched into shadow registers and `pend` is set.
  - `cfg_ready = !pend && state!=LOAD`. Exactly one configuration is buffered; further offers stall.
- State IDLE:
  - `cnt` held at 0, no ticks, `led` holds.
  - `pend` → LOAD. Otherwise `run` → RUN.
- State RUN:
  - `cnt` increments each cycle.
  - When `cnt==div`: `cnt`←0, `tick`←1, `led` steps.
  - If `pend` is set on that same edge → LOAD.
  - `run`=0 → IDLE next edge. `cnt` clears and the partial period is discarded. If `run` falls on the terminal edge, the tick still fires and IDLE wins over LOAD; `pend` is then handled from IDLE.
- State LOAD, one cycle:
  - `div`/`mode` ← shadow, `pend`←0, `cnt`←0.
  - `led` ← seed: count 16'h0000, walk-left 16'h0001, walk-right 16'h8000, hold unchanged.
  - Next state: RUN if `run`, else IDLE.
- LED step:
  - Count: `led+1`, wraps FFFF→0000.
  - Walk-left: rotate left, 8000→0001.
  - Walk-right: rotate right, 0001→8000.
  - Hold: unchanged, but `tick` still pulses.
- A rotate from 0000 stays 0000; the seed applies only via LOAD.
- Width rule: `cnt` compare is equality on CNT_W bits, and `cfg_div` is used unmodified.
- `rst` asserted mid-operation returns all registers to reset values immediately and drops any pending configuration.

## Timing
- IDLE→RUN on the first edge with `run`=1 sampled.
- First `tick` is high in cycle `div+1` after entering RUN, then every `div+1` cycles. `led` changes on the same edge that raises `tick`.
- Configuration accepted in RUN takes effect at the next tick edge + 1 cycle (LOAD). The period following LOAD is a full new `div+1`.
- Configuration accepted in IDLE reaches LOAD on the next edge. `cfg_ready` returns high the cycle after LOAD.
- `cfg_valid` and a rising `run` on the same edge in IDLE: configuration is accepted, IDLE→LOAD→RUN. The first tick is then `div+1` cycles after RUN entry.
- `tick` is never high in IDLE or LOAD.

## Configuration
- `CLK_SCHED_SYNC_RUN_EN`: when defined, `run` passes through a two-flop synchronizer, reset to 0, before the FSM. This adds exactly 2 cycles to both start and stop latency.
- When undefined, `run` is sampled directly, for internally generated or already-synchronous sources.

## Test plan
All tests override `DEF_DIV`=3 and leave the macro undefined unless noted.
- Reset then `run`=1: `tick` pulses every 4 cycles. `led` reads 0001, 0002, 0003 after ticks 1–3, and `busy`=1.
- While running, offer `cfg_div`=1, `cfg_mode`=01:
  - `cfg_ready` drops the cycle after the transfer.
  - After the next tick, a LOAD cycle sets `led`=0001.
  - Then `tick` pulses every 2 cycles with `led` 0002, 0004, ….
- Walk-right with `div`=0 for 17 cycles: `tick` stays high every cycle and `led` wraps 0001→8000 on the 16th step.
- Drop `run` at `cnt`=2 with `div`=3: no tick fires. Raising `run` again gives the first tick 4 cycles later.
- `run` rising and `cfg_valid` together in IDLE: sequence LOAD then RUN, and the first tick follows after `cfg_div+1` cycles.
- Assert `rst` mid-period with `pend`=1: `led`=0000, `cfg_ready`=1, `tick`=0 immediately. With `CLK_SCHED_SYNC_RUN_EN` defined, the first tick arrives 2 cycles later than without it.
